// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, FSM states and alignment check shared by mem_unit.
// Contents:
//   size_e     - access size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DOUBLE
//   state_e    - mem_unit FSM states (SWAP_WR only with MEM_SWAP_EN defined)
//   is_aligned - natural-alignment check on the low three address bits
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        BEAT,
`ifdef MEM_SWAP_EN
        SWAP_WR,
`endif
        DONE
    } state_e;

    function automatic logic is_aligned(size_e sz, logic [2:0] a);
        return sz == SZ_BYTE ? 1'b1 :
               sz == SZ_HALF ? !a[0] :
               sz == SZ_WORD ? a[1:0] == 2'b00 :
                               a == 3'b000;
    endfunction

endpackage

// File: rtl/mem_if.sv
// mem_if: request/response bundle between the control unit (master) and mem_unit (slave).
// Signals:
//   MOV, RW, Size, Signed, Swap     - request strobe and access attributes (master -> slave)
//   MAR_Address, MDR_DataIn         - byte address and store data (master -> slave)
//   MDR_DataOut                     - load result (slave -> master)
//   MFC, Busy, AlignErr             - completion pulse, busy flag, rejection flag (slave -> master)
interface mem_if #(
    parameter int ADDR_WIDTH = 9
);

    logic                  MOV;
    logic                  RW;
    logic [1:0]            Size;
    logic                  Signed;
    logic                  Swap;
    logic [ADDR_WIDTH-1:0] MAR_Address;
    logic [63:0]           MDR_DataIn;
    logic [63:0]           MDR_DataOut;
    logic                  MFC;
    logic                  Busy;
    logic                  AlignErr;

    modport master (
        output MOV, RW, Size, Signed, Swap, MAR_Address, MDR_DataIn,
        input  MDR_DataOut, MFC, Busy, AlignErr
    );

    modport slave (
        input  MOV, RW, Size, Signed, Swap, MAR_Address, MDR_DataIn,
        output MDR_DataOut, MFC, Busy, AlignErr
    );

endinterface

// File: rtl/mem_byte_array.sv
// mem_byte_array: byte storage with a 4-byte big-endian read window and byte-enabled write.
// Ports:
//   clk   - write clock, rising edge
//   addr  - window base; byte addr -> rdata[31:24], addr+3 -> rdata[7:0] (wraps at depth)
//   be    - byte enables, be[3] writes addr ... be[0] writes addr+3
//   wdata - write data, same lane mapping as rdata
//   rdata - combinational read of the window
// Contents are deliberately not reset.
module mem_byte_array #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++)
            rdata[31-8*i -: 8] = mem[addr + ADDR_WIDTH'(i)];
    end

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (be[3-i])
                mem[addr + ADDR_WIDTH'(i)] <= wdata[31-8*i -: 8];

endmodule

// File: rtl/mem_unit.sv
// mem_unit: big-endian byte-addressed data memory with wait states and MFC handshake.
// Ports:
//   Clk     - clock, rising edge
//   Reset_n - asynchronous active-low reset
//   bus     - mem_if slave: MOV/RW/Size/Signed/Swap/MAR_Address/MDR_DataIn in,
//             MDR_DataOut/MFC/Busy/AlignErr out
// Parameters: ADDR_WIDTH (byte-address width), WAIT_STATES (0..15 cycles before each beat).
// Optional feature: define MEM_SWAP_EN to enable the atomic word SWAP.
module mem_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 1
) (
    input logic  Clk,
    input logic  Reset_n,
    mem_if.slave bus
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e                state;
    logic [3:0]            cnt;
    logic                  second;
    logic                  rw_q;
    logic                  sgn_q;
    size_e                 size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [63:0]           data_q;
    logic [31:0]           hi_q;
    size_e                 req_size;
    logic                  rd_en;
    logic                  wr_en;
    logic [3:0]            be;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic [63:0]           ld_val;
`ifdef MEM_SWAP_EN
    logic                  swap_q;
    state_e                next_beat;
`else
    localparam logic       swap_q = 1'b0;
`endif

    always_comb begin
`ifdef MEM_SWAP_EN
        // A swap is a word access regardless of the Size field.
        req_size  = bus.Swap ? SZ_WORD : size_e'(bus.Size);
        next_beat = swap_q && (second || state == BEAT) ? SWAP_WR : BEAT;
        wr_en     = (state == BEAT && !rw_q && !swap_q) || state == SWAP_WR;
`else
        req_size  = size_e'(bus.Size);
        wr_en     = state == BEAT && !rw_q;
`endif
        rd_en    = state == BEAT && (rw_q || swap_q);
        be       = !wr_en ? 4'b0000 : size_q == SZ_BYTE ? 4'b1000 : size_q == SZ_HALF ? 4'b1100 : 4'b1111;
        // Second word of a double lives at A+4; a swap write reuses A.
        win_addr = addr_q + ADDR_WIDTH'({second && size_q == SZ_DOUBLE, 2'b00});
        wdata    = size_q == SZ_DOUBLE ? (second ? data_q[31:0] : data_q[63:32]) :
                   size_q == SZ_HALF   ? {data_q[15:0], 16'b0} :
                   size_q == SZ_BYTE   ? {data_q[7:0], 24'b0} :
                                         data_q[31:0];
        ld_val   = size_q == SZ_BYTE ? {32'b0, {24{sgn_q & rdata[31]}}, rdata[31:24]} :
                   size_q == SZ_HALF ? {32'b0, {16{sgn_q & rdata[31]}}, rdata[31:16]} :
                   size_q == SZ_WORD ? {32'b0, rdata} :
                                       {hi_q, rdata};
    end

    mem_byte_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (Clk),
        .addr  (win_addr),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            second          <= 1'b0;
            rw_q            <= 1'b0;
            sgn_q           <= 1'b0;
            size_q          <= SZ_BYTE;
            addr_q          <= '0;
            data_q          <= '0;
            hi_q            <= '0;
`ifdef MEM_SWAP_EN
            swap_q          <= 1'b0;
`endif
            bus.MDR_DataOut <= '0;
            bus.MFC         <= 1'b0;
            bus.Busy        <= 1'b0;
            bus.AlignErr    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.MOV) begin
                    rw_q     <= bus.RW;
                    sgn_q    <= bus.Signed;
                    size_q   <= req_size;
                    addr_q   <= bus.MAR_Address;
                    data_q   <= bus.MDR_DataIn;
`ifdef MEM_SWAP_EN
                    swap_q   <= bus.Swap;
`endif
                    second   <= 1'b0;
                    cnt      <= WS;
                    bus.Busy <= 1'b1;
                    if (!is_aligned(req_size, bus.MAR_Address[2:0])) begin
                        state        <= DONE;
                        bus.MFC      <= 1'b1;
                        bus.AlignErr <= 1'b1;
                    end else begin
                        state <= WS == 4'd0 ? BEAT : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
`ifdef MEM_SWAP_EN
                    if (cnt == 4'd1) state <= next_beat;
`else
                    if (cnt == 4'd1) state <= BEAT;
`endif
                end
                BEAT: begin
                    // The first word of a double load is parked so MDR_DataOut only moves at the final beat.
                    if (rd_en && size_q == SZ_DOUBLE && !second)
                        hi_q <= rdata;
                    else if (rd_en)
                        bus.MDR_DataOut <= ld_val;
                    if (!second && (size_q == SZ_DOUBLE || swap_q)) begin
                        second <= 1'b1;
                        cnt    <= WS;
`ifdef MEM_SWAP_EN
                        state  <= WS == 4'd0 ? next_beat : WAIT;
`else
                        state  <= WS == 4'd0 ? BEAT : WAIT;
`endif
                    end else begin
                        state   <= DONE;
                        bus.MFC <= 1'b1;
                    end
                end
`ifdef MEM_SWAP_EN
                SWAP_WR: begin
                    state   <= DONE;
                    bus.MFC <= 1'b1;
                end
`endif
                DONE: begin
                    state        <= IDLE;
                    bus.MFC      <= 1'b0;
                    bus.Busy     <= 1'b0;
                    bus.AlignErr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: self-checking bench for mem_unit (WAIT_STATES = 1, ADDR_WIDTH = 9).
module tb_mem_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_if #(.ADDR_WIDTH(9)) bus ();

    mem_unit #(.ADDR_WIDTH(9), .WAIT_STATES(1)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic        swp;
        logic [8:0]  addr;
        logic [63:0] din;
        logic [63:0] exp_out;
        logic        exp_err;
        int          exp_edge;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          edge_n;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic void add(logic rw, logic [1:0] sz, logic sg, logic sw, logic [8:0] a,
                                logic [63:0] d, logic [63:0] eo, logic ee, int el);
        vecs.push_back('{rw, sz, sg, sw, a, d, eo, ee, el});
    endfunction

    // exp_edge: index of the clock edge (accept edge = 0) after which MFC is high.
    task automatic run_op(input string tag, input vec_t v);
        exp_t e;
        int   n;
        bit   seen;
        exp_q.push_back('{v.exp_out, v.exp_err, v.exp_edge});
        @(negedge clk);
        bus.MOV         = 1'b1;
        bus.RW          = v.rw;
        bus.Size        = v.size;
        bus.Signed      = v.sgn;
        bus.Swap        = v.swp;
        bus.MAR_Address = v.addr;
        bus.MDR_DataIn  = v.din;
        @(posedge clk);
        #1;
        bus.MOV = 1'b0;
        chk({tag, " busy"}, 64'(bus.Busy), 64'd1);
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.MFC) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: MFC not seen within 40 cycles, required by edge %0d", tag, v.exp_edge);
        end
        e = exp_q.pop_front();
        chk({tag, " data"}, bus.MDR_DataOut, e.data);
        chk({tag, " alignerr"}, 64'(bus.AlignErr), 64'(e.err));
        chk({tag, " mfc_edge"}, 64'(n), 64'(e.edge_n));
        @(posedge clk);
        #1;
        chk({tag, " mfc_pulse"}, 64'(bus.MFC), 64'd0);
        chk({tag, " busy_drop"}, 64'(bus.Busy), 64'd0);
        chk({tag, " alignerr_drop"}, 64'(bus.AlignErr), 64'd0);
    endtask

    initial begin
        bus.MOV = 1'b0;
        bus.RW = 1'b0;
        bus.Size = 2'b00;
        bus.Signed = 1'b0;
        bus.Swap = 1'b0;
        bus.MAR_Address = '0;
        bus.MDR_DataIn = '0;

        //   rw    size       sg    sw    addr    din                     exp_out                 err   edge
        add(1'b0, SZ_WORD,   1'b0, 1'b0, 9'h010, 64'h00000000_DEADBEEF, 64'h00000000_00000000, 1'b0, 2);
        add(1'b1, SZ_WORD,   1'b0, 1'b0, 9'h010, 64'h0,                 64'h00000000_DEADBEEF, 1'b0, 2);
        add(1'b0, SZ_BYTE,   1'b0, 1'b0, 9'h021, 64'h00000000_00000080, 64'h00000000_DEADBEEF, 1'b0, 2);
        add(1'b1, SZ_BYTE,   1'b1, 1'b0, 9'h021, 64'h0,                 64'h00000000_FFFFFF80, 1'b0, 2);
        add(1'b1, SZ_BYTE,   1'b0, 1'b0, 9'h021, 64'h0,                 64'h00000000_00000080, 1'b0, 2);
        add(1'b0, SZ_BYTE,   1'b0, 1'b0, 9'h022, 64'h00000000_0000007F, 64'h00000000_00000080, 1'b0, 2);
        add(1'b1, SZ_BYTE,   1'b1, 1'b0, 9'h022, 64'h0,                 64'h00000000_0000007F, 1'b0, 2);
        add(1'b0, SZ_DOUBLE, 1'b0, 1'b0, 9'h040, 64'h11223344_55667788, 64'h00000000_0000007F, 1'b0, 4);
        add(1'b1, SZ_DOUBLE, 1'b0, 1'b0, 9'h040, 64'h0,                 64'h11223344_55667788, 1'b0, 4);
        add(1'b1, SZ_BYTE,   1'b0, 1'b0, 9'h047, 64'h0,                 64'h00000000_00000088, 1'b0, 2);
        add(1'b1, SZ_HALF,   1'b1, 1'b0, 9'h044, 64'h0,                 64'h00000000_00005566, 1'b0, 2);
        add(1'b0, SZ_HALF,   1'b0, 1'b0, 9'h032, 64'h00000000_0000A5F0, 64'h00000000_00005566, 1'b0, 2);
        add(1'b1, SZ_HALF,   1'b1, 1'b0, 9'h032, 64'h0,                 64'h00000000_FFFFA5F0, 1'b0, 2);
        add(1'b1, SZ_HALF,   1'b0, 1'b0, 9'h031, 64'h0,                 64'h00000000_FFFFA5F0, 1'b1, 0);
        add(1'b0, SZ_WORD,   1'b0, 1'b0, 9'h012, 64'h00000000_01020304, 64'h00000000_FFFFA5F0, 1'b1, 0);
        add(1'b0, SZ_DOUBLE, 1'b0, 1'b0, 9'h044, 64'h0,                 64'h00000000_FFFFA5F0, 1'b1, 0);
        add(1'b1, SZ_HALF,   1'b0, 1'b0, 9'h032, 64'h0,                 64'h00000000_0000A5F0, 1'b0, 2);
        add(1'b1, SZ_WORD,   1'b0, 1'b0, 9'h010, 64'h0,                 64'h00000000_DEADBEEF, 1'b0, 2);
        add(1'b0, SZ_WORD,   1'b0, 1'b0, 9'h1FC, 64'h00000000_CAFEF00D, 64'h00000000_DEADBEEF, 1'b0, 2);
        add(1'b1, SZ_WORD,   1'b0, 1'b0, 9'h1FC, 64'h0,                 64'h00000000_CAFEF00D, 1'b0, 2);
        add(1'b1, SZ_DOUBLE, 1'b0, 1'b0, 9'h040, 64'h0,                 64'h11223344_55667788, 1'b0, 4);
        add(1'b0, SZ_WORD,   1'b0, 1'b0, 9'h084, 64'h00000000_5A5A5A5A, 64'h11223344_55667788, 1'b0, 2);
        add(1'b0, SZ_WORD,   1'b0, 1'b0, 9'h00C, 64'h00000000_AAAA5555, 64'h11223344_55667788, 1'b0, 2);
`ifdef MEM_SWAP_EN
        add(1'b0, SZ_BYTE,   1'b0, 1'b1, 9'h00C, 64'h00000000_12345678, 64'h00000000_AAAA5555, 1'b0, 4);
        add(1'b1, SZ_WORD,   1'b0, 1'b0, 9'h00C, 64'h0,                 64'h00000000_12345678, 1'b0, 2);
`else
        add(1'b1, SZ_WORD,   1'b0, 1'b1, 9'h00C, 64'h0,                 64'h00000000_AAAA5555, 1'b0, 2);
        add(1'b0, SZ_WORD,   1'b0, 1'b1, 9'h00C, 64'h00000000_12345678, 64'h00000000_AAAA5555, 1'b0, 2);
        add(1'b1, SZ_WORD,   1'b0, 1'b0, 9'h00C, 64'h0,                 64'h00000000_12345678, 1'b0, 2);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset data", bus.MDR_DataOut, 64'h0);
        chk("reset mfc", 64'(bus.MFC), 64'd0);
        chk("reset busy", 64'(bus.Busy), 64'd0);
        chk("reset alignerr", 64'(bus.AlignErr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i]);

        // Reset during the second beat of a double store at 0x080.
        @(negedge clk);
        bus.MOV = 1'b1;
        bus.RW = 1'b0;
        bus.Size = SZ_DOUBLE;
        bus.Signed = 1'b0;
        bus.Swap = 1'b0;
        bus.MAR_Address = 9'h080;
        bus.MDR_DataIn = 64'hA1B2C3D4_E5F60718;
        @(posedge clk);
        #1;
        bus.MOV = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midreset busy_before", 64'(bus.Busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset data", bus.MDR_DataOut, 64'h0);
        chk("midreset mfc", 64'(bus.MFC), 64'd0);
        chk("midreset busy", 64'(bus.Busy), 64'd0);
        chk("midreset alignerr", 64'(bus.AlignErr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("midreset first_word", '{1'b1, SZ_WORD, 1'b0, 1'b0, 9'h080, 64'h0, 64'h00000000_A1B2C3D4, 1'b0, 2});
        run_op("midreset second_word", '{1'b1, SZ_WORD, 1'b0, 1'b0, 9'h084, 64'h0, 64'h00000000_5A5A5A5A, 1'b0, 2});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
